// File: rtl/ldr_writeback_queue.sv
// ldr_writeback_queue
//   In-order tracking queue for outstanding loads. Each accepted load records
//   its destination register. Memory responses retire the oldest entry and
//   produce a registered register-file write one cycle later.
//
//   Optional build macro: LDR_WB_ERR_CHECK_EN
//     defined   : err is a sticky flag set by a response arriving with nothing
//                 pending; only reset clears it
//     undefined : err is tied low and the orphan detector is not built
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   issue_valid, opcode  presented instruction and its decoded opcode
//   issue_rd             destination register of the presented instruction
//   issue_ready          queue has room for another load
//   mem_rvalid/mem_rdata load response from memory (returned in issue order)
//   chk_rd, chk_hit      load-use hazard query against pending destinations
//   w_en_ldr/w_addr_ldr/w_data_ldr  register-file write port for load data
//   pending_count        number of outstanding loads
//   err                  sticky protocol error (see macro above)
module ldr_writeback_queue #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  input  logic [6:0]                 opcode,
  input  logic [RADDR_W-1:0]         issue_rd,
  output logic                       issue_ready,
  input  logic                       mem_rvalid,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic [RADDR_W-1:0]         chk_rd,
  output logic                       chk_hit,
  output logic                       w_en_ldr,
  output logic [RADDR_W-1:0]         w_addr_ldr,
  output logic [DATA_W-1:0]          w_data_ldr,
  output logic [$clog2(DEPTH+1)-1:0] pending_count,
  output logic                       err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [RADDR_W-1:0] rd_mem_q [DEPTH];
  logic [RADDR_W-1:0] rd_mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               w_en_q, w_en_d;
  logic [RADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0]  w_data_q, w_data_d;

  logic is_load;
  logic push;
  logic pop;

  assign is_load = (opcode[6:4] == 3'b110) || (opcode[6:3] == 4'b1000);
  // Both decisions use the registered count: a load issued into an empty
  // queue cannot be retired by a response in the same cycle, and a full
  // queue drops the issue even if a slot frees up this cycle.
  assign push    = issue_valid && is_load && (count_q < CNT_W'(DEPTH));
  assign pop     = mem_rvalid && (count_q != '0);

  always_comb begin
    rd_mem_d = rd_mem_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    w_en_d   = pop;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (push) begin
      rd_mem_d[tail_q] = issue_rd;
      tail_d           = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d   = head_q + PTR_W'(1);
      w_addr_d = rd_mem_q[head_q];
      w_data_d = mem_rdata;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rd_mem_q[i] <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      rd_mem_q <= rd_mem_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  // Only entries between head and head+count are live; stale slots are
  // masked. The entry being popped this cycle is still live here because
  // count_q has not yet decremented.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (rd_mem_q[idx] == chk_rd)) chk_hit = 1'b1;
    end
  end

`ifdef LDR_WB_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb err_d = err_q | (mem_rvalid && (count_q == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign issue_ready   = count_q < CNT_W'(DEPTH);
  assign pending_count = count_q;
  assign w_en_ldr      = w_en_q;
  assign w_addr_ldr    = w_addr_q;
  assign w_data_ldr    = w_data_q;

endmodule

// File: tb/tb_ldr_writeback_queue.sv
module tb_ldr_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [6:0]  opcode;
  logic [3:0]  issue_rd;
  logic        issue_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [3:0]  chk_rd;
  logic        chk_hit;
  logic        w_en_ldr;
  logic [3:0]  w_addr_ldr;
  logic [31:0] w_data_ldr;
  logic [2:0]  pending_count;
  logic        err;

  ldr_writeback_queue #(.DEPTH(DEPTH), .DATA_W(32), .RADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .opcode(opcode),
    .issue_rd(issue_rd), .issue_ready(issue_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .chk_rd(chk_rd), .chk_hit(chk_hit),
    .w_en_ldr(w_en_ldr), .w_addr_ldr(w_addr_ldr), .w_data_ldr(w_data_ldr),
    .pending_count(pending_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    logic [6:0] op;
    bit         exp_load;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [3:0]  m_rd[$];
  wb_t         exp_q[$];
  logic [3:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  bit          m_err = 1'b0;

  localparam logic [6:0] LD  = 7'b1100000;
  localparam logic [6:0] LD2 = 7'b1000101;
  localparam logic [6:0] ALU = 7'b0000001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit tb_is_load(input logic [6:0] op);
    return (op ==? 7'b110????) || (op ==? 7'b1000???);
  endfunction

  // Called right after a falling edge; returns right after the next one.
  task automatic step(input bit iv, input logic [6:0] op, input logic [3:0] rd,
                      input bit rv, input logic [31:0] data, input logic [3:0] chk);
    bit  acc, pp, hit;
    wb_t e;
    issue_valid = iv; opcode = op; issue_rd = rd;
    mem_rvalid = rv; mem_rdata = data; chk_rd = chk;
    #1;
    hit = 1'b0;
    foreach (m_rd[k]) if (m_rd[k] == chk) hit = 1'b1;
    check("chk_hit", 32'(chk_hit), 32'(hit));
    check("issue_ready", 32'(issue_ready), 32'(m_rd.size() < DEPTH));
    check("pending_count", 32'(pending_count), 32'(m_rd.size()));
    check("err", 32'(err), 32'(m_err));
    acc = iv && tb_is_load(op) && (m_rd.size() < DEPTH);
    pp  = rv && (m_rd.size() > 0);
`ifdef LDR_WB_ERR_CHECK_EN
    if (rv && m_rd.size() == 0) m_err = 1'b1;
`endif
    if (pp) begin
      e.rd = m_rd.pop_front();
      e.data = data;
      exp_q.push_back(e);
    end
    if (acc) m_rd.push_back(rd);
    @(posedge clk); #1;
    check("w_en_ldr", 32'(w_en_ldr), 32'(pp));
    if (w_en_ldr && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_addr = e.rd;
      last_data = e.data;
    end
    check("w_addr_ldr", 32'(w_addr_ldr), 32'(last_addr));
    check("w_data_ldr", w_data_ldr, last_data);
    issue_valid = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input logic [3:0] chk);
    step(1'b0, 7'b0, 4'd0, 1'b0, 32'd0, chk);
  endtask

  task automatic drain();
    while (m_rd.size() > 0) step(1'b0, 7'b0, 4'd0, 1'b1, $urandom, 4'd15);
    idle(4'd15);
  endtask

  vec_t vecs[10];
  int   exp_cnt;

  initial begin
    vecs[0] = '{7'b1100000, 1'b1};
    vecs[1] = '{7'b0000001, 1'b0};
    vecs[2] = '{7'b1101111, 1'b1};
    vecs[3] = '{7'b1001000, 1'b0};
    vecs[4] = '{7'b1000000, 1'b1};
    vecs[5] = '{7'b1110000, 1'b0};
    vecs[6] = '{7'b0110000, 1'b0};
    vecs[7] = '{7'b1000111, 1'b1};
    vecs[8] = '{7'b1010000, 1'b0};
    vecs[9] = '{7'b0100000, 1'b0};

    rst_n = 1'b0; issue_valid = 1'b0; opcode = '0; issue_rd = '0;
    mem_rvalid = 1'b0; mem_rdata = '0; chk_rd = '0;
    #1;
    check("rst_count", 32'(pending_count), 32'd0);
    check("rst_w_en", 32'(w_en_ldr), 32'd0);
    check("rst_w_addr", 32'(w_addr_ldr), 32'd0);
    check("rst_w_data", w_data_ldr, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(issue_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // single load, response three cycles later
    step(1'b1, LD, 4'd5, 1'b0, 32'd0, 4'd5);
    idle(4'd5); idle(4'd5);
    step(1'b0, 7'b0, 4'd0, 1'b1, 32'hDEADBEEF, 4'd5);
    check("single_wb_addr", 32'(w_addr_ldr), 32'd5);
    check("single_wb_data", w_data_ldr, 32'hDEADBEEF);
    idle(4'd5);

    // opcode decode table
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, vecs[i].op, 4'(i), 1'b0, 32'd0, 4'(i));
      if (vecs[i].exp_load) exp_cnt++;
      check($sformatf("decode_%0d", i), 32'(pending_count), 32'(exp_cnt));
    end
    drain();

    // fill to full, hold rd=6 while full, drain back-to-back
    for (int i = 1; i <= 4; i++) step(1'b1, LD, 4'(i), 1'b0, 32'd0, 4'd6);
    check("full_ready", 32'(issue_ready), 32'd0);
    step(1'b1, LD, 4'd6, 1'b0, 32'd0, 4'd6);
    step(1'b1, LD, 4'd6, 1'b1, 32'h11110001, 4'd6);
    check("full_drop", 32'(pending_count), 32'd3);
    for (int i = 2; i <= 4; i++) step(1'b0, 7'b0, 4'd0, 1'b1, 32'h11110000 + 32'(i), 4'd6);
    check("full_last_addr", 32'(w_addr_ldr), 32'd4);
    idle(4'd6);

    // simultaneous issue and pop at count 2, then a wrapping run
    step(1'b1, LD2, 4'd10, 1'b0, 32'd0, 4'd9);
    step(1'b1, LD2, 4'd11, 1'b0, 32'd0, 4'd9);
    step(1'b1, LD, 4'd9, 1'b1, 32'hA5A50010, 4'd9);
    check("sim_count", 32'(pending_count), 32'd2);
    check("sim_head_addr", 32'(w_addr_ldr), 32'd10);
    drain();
    check("sim_last_addr", 32'(w_addr_ldr), 32'd9);
    for (int i = 0; i < 10; i++) step(1'b1, LD, 4'(i), (i >= 2), $urandom, 4'(i));
    drain();

    // ALU issue and hazard query
    step(1'b1, ALU, 4'd7, 1'b0, 32'd0, 4'd7);
    check("alu_count", 32'(pending_count), 32'd0);
    step(1'b1, LD, 4'd7, 1'b0, 32'd0, 4'd7);
    step(1'b1, LD, 4'd3, 1'b0, 32'd0, 4'd7);
    step(1'b0, 7'b0, 4'd0, 1'b1, 32'h77, 4'd7);
    check("hazard_after_pop", 32'(chk_hit), 32'd0);
    idle(4'd3);
    drain();

    // orphan responses, including issue-and-respond into an empty queue
    step(1'b0, 7'b0, 4'd0, 1'b1, 32'hBAD0, 4'd0);
    step(1'b1, LD, 4'd8, 1'b1, 32'hBAD1, 4'd8);
    drain();

    // reset with loads pending and a writeback in flight
    for (int i = 1; i <= 3; i++) step(1'b1, LD, 4'(i + 11), 1'b0, 32'd0, 4'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_w_en", 32'(w_en_ldr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(pending_count), 32'd0);
    check("mid_rst_w_en", 32'(w_en_ldr), 32'd0);
    check("mid_rst_w_addr", 32'(w_addr_ldr), 32'd0);
    m_rd.delete(); exp_q.delete();
    last_addr = '0; last_data = '0; m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4'd12);
    step(1'b0, 7'b0, 4'd0, 1'b1, 32'hCAFE0002, 4'd12);
    idle(4'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
